// File: rtl/shift_sched_pkg.sv
// Shared constants, state encoding and the per-pass step helper for the
// two-requester shift scheduler.
package shift_sched_pkg;

  localparam int WIDTH    = 8;
  localparam int AMT_W    = 3;
  localparam int STEP_W   = 2;
  localparam int MAX_STEP = (1 << STEP_W) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Largest step the stage can take without overshooting the remaining amount.
  function automatic logic [STEP_W-1:0] pass_step(input logic [AMT_W-1:0] rem);
    if (rem > AMT_W'(MAX_STEP)) begin
      pass_step = STEP_W'(MAX_STEP);
    end else begin
      pass_step = rem[STEP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/shift_sched_if.sv
// Command and result handshake bundle between the clients and the scheduler.
interface shift_sched_if
  import shift_sched_pkg::*;
();

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic [AMT_W-1:0] req0_amt;
  logic             req0_dir;
  logic             req0_rot;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic [AMT_W-1:0] req1_amt;
  logic             req1_dir;
  logic             req1_rot;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;

  modport master (
    output req0_valid, req0_data, req0_amt, req0_dir, req0_rot,
    output req1_valid, req1_data, req1_amt, req1_dir, req1_rot,
    output res_ready,
    input  req0_ready, req1_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_dir, req0_rot,
    input  req1_valid, req1_data, req1_amt, req1_dir, req1_rot,
    input  res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_id
  );

endinterface

// File: rtl/shift_sched_stage.sv
// Combinational shift/rotate by 0..MAX_STEP: one (MAX_STEP+1):1 mux per output
// bit, candidates wired statically from the neighbouring input bits.
module shift_stage
  import shift_sched_pkg::*;
(
  input  logic [WIDTH-1:0]  i_data,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_dir,
  input  logic              i_rot,
  output logic [WIDTH-1:0]  o_data
);

  logic [WIDTH-1:0][MAX_STEP:0] w_cand;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    for (genvar k = 0; k <= MAX_STEP; k++) begin : g_step
      localparam int LI    = (b - k + WIDTH) % WIDTH;
      localparam int RI    = (b + k) % WIDTH;
      localparam bit LWRAP = (b < k);
      localparam bit RWRAP = ((b + k) >= WIDTH);
      logic w_left;
      logic w_right;
      // Bits that wrap past the edge are only kept when rotating.
      assign w_left  = (LWRAP && !i_rot) ? 1'b0 : i_data[LI];
      assign w_right = (RWRAP && !i_rot) ? 1'b0 : i_data[RI];
      assign w_cand[b][k] = (i_dir == DIR_RIGHT) ? w_right : w_left;
    end
    assign o_data[b] = w_cand[b][i_step];
  end

endmodule

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one shift stage between two requesters;
// long shifts are split into multiple passes of at most MAX_STEP bits.
module shift_sched
  import shift_sched_pkg::*;
(
  input logic          clk,
  input logic          rst,
  shift_sched_if.slave bus
);

  state_t            r_state;
  state_t            w_next_state;
  logic [WIDTH-1:0]  r_acc;
  logic [AMT_W-1:0]  r_remaining;
  logic              r_dir;
  logic              r_rot;
  logic              r_res_id;
  logic              r_last_id;
  logic              r_res_valid;

  logic              w_gnt_any;
  logic              w_gnt_id;
  logic              w_accept;
  logic [WIDTH-1:0]  w_sel_data;
  logic [AMT_W-1:0]  w_sel_amt;
  logic              w_sel_dir;
  logic              w_sel_rot;
  logic [STEP_W-1:0] w_step;
  logic [AMT_W-1:0]  w_rem_next;
  logic [WIDTH-1:0]  w_stage_out;

  // Round-robin arbiter: on contention the requester not served last wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_gnt_any = 1'b1;
      w_gnt_id  = ~r_last_id;
    end else if (bus.req0_valid) begin
      w_gnt_any = 1'b1;
      w_gnt_id  = 1'b0;
    end else if (bus.req1_valid) begin
      w_gnt_any = 1'b1;
      w_gnt_id  = 1'b1;
    end else begin
      w_gnt_any = 1'b0;
      w_gnt_id  = 1'b0;
    end
  end

  assign w_accept       = (r_state == IDLE) && w_gnt_any;
  assign bus.req0_ready = w_accept && (w_gnt_id == 1'b0);
  assign bus.req1_ready = w_accept && (w_gnt_id == 1'b1);

  assign w_sel_data = w_gnt_id ? bus.req1_data : bus.req0_data;
  assign w_sel_amt  = w_gnt_id ? bus.req1_amt  : bus.req0_amt;
  assign w_sel_dir  = w_gnt_id ? bus.req1_dir  : bus.req0_dir;
  assign w_sel_rot  = w_gnt_id ? bus.req1_rot  : bus.req0_rot;

  assign w_step     = pass_step(r_remaining);
  assign w_rem_next = r_remaining - AMT_W'(w_step);

  shift_stage u_stage (
    .i_data (r_acc),
    .i_step (w_step),
    .i_dir  (r_dir),
    .i_rot  (r_rot),
    .o_data (w_stage_out)
  );

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = (w_sel_amt == {AMT_W{1'b0}}) ? DONE : SHIFT;
        end else begin
          w_next_state = IDLE;
        end
      end
      SHIFT: begin
        if (w_rem_next == {AMT_W{1'b0}}) begin
          w_next_state = DONE;
        end else begin
          w_next_state = SHIFT;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Command capture, per-pass accumulation and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= {WIDTH{1'b0}};
      r_remaining <= {AMT_W{1'b0}};
      r_dir       <= 1'b0;
      r_rot       <= 1'b0;
      r_res_id    <= 1'b0;
      r_last_id   <= 1'b1;
      r_res_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc       <= w_sel_data;
        r_remaining <= w_sel_amt;
        r_dir       <= w_sel_dir;
        r_rot       <= w_sel_rot;
        r_res_id    <= w_gnt_id;
        r_last_id   <= w_gnt_id;
      end else if (r_state == SHIFT) begin
        r_acc       <= w_stage_out;
        r_remaining <= w_rem_next;
      end
      r_res_valid <= (w_next_state == DONE);
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_acc;
  assign bus.res_id    = r_res_id;

endmodule
